// File: rtl/mic_cic_frame_scheduler.sv
// mic_cic_frame_scheduler
//   Drives the shared active-low reset of a bank of NUM_CH CIC decimators,
//   waits out a settle window after filter release, then captures each
//   channel's output on its out_valid strobe into a one-deep holding slot
//   and serialises the slots in strict channel order 0..NUM_CH-1 over a
//   valid/ready stream. Samples that arrive while their slot is still
//   occupied are dropped and flagged in a sticky per-channel overrun vector.
//
//   Build option: define MIC_SCHED_FRAME_CNT_EN to build a 16-bit counter of
//   completed frames on frame_cnt. Without it frame_cnt is tied to zero and
//   no counter logic exists; the port list is the same in both builds.

module mic_cic_frame_scheduler #(
    parameter int NUM_CH        = 8,
    parameter int DATA_W        = 16,
    parameter int SETTLE_CYCLES = 4096,
    parameter int CNT_W         = 13,
    parameter int CH_W          = 3
) (
    input  logic                     clk_in,
    input  logic                     reset_n,
    input  logic                     enable,
    input  logic [NUM_CH-1:0]        ch_valid,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    output logic                     filt_reset_n,
    output logic [DATA_W-1:0]        out_data,
    output logic [CH_W-1:0]          out_ch,
    output logic                     out_sof,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NUM_CH-1:0]        overrun,
    input  logic                     overrun_clr,
    output logic                     busy,
    output logic [15:0]              frame_cnt
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_RUN    = 2'd2;
    localparam logic [1:0] ST_DRAIN  = 2'd3;

    localparam logic [CH_W-1:0]  LAST_CH     = CH_W'(NUM_CH - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [CNT_W-1:0]  settle_cnt;
    logic [NUM_CH-1:0] full;
    logic [NUM_CH-1:0] full_nxt;
    logic [CH_W-1:0]   ptr;
    logic [CH_W-1:0]   ptr_nxt;
    logic [NUM_CH-1:0] overrun_nxt;
    logic [DATA_W-1:0] hold [NUM_CH];

    // Per-cycle decode
    logic              emitting;     // RUN or DRAIN: the head slot may be presented
    logic              handshake;    // head slot accepted this cycle
    logic              last_hs;      // accepted slot closes the frame
    logic              go_idle;      // taking an IDLE transition this cycle
    logic [NUM_CH-1:0] capture;      // ch_valid qualified by the capture window
    logic [NUM_CH-1:0] clear_vec;    // one-hot of the slot being released
    logic [NUM_CH-1:0] load;         // slots written with a fresh sample
    logic [NUM_CH-1:0] drop;         // samples lost to an occupied slot

    // ------------------------------------------------------------------
    // Output decode. Everything here is a function of registers only, so
    // out_ready and ch_valid never reach an output combinationally.
    // ------------------------------------------------------------------
    assign emitting     = (state == ST_RUN) || (state == ST_DRAIN);
    assign out_valid    = emitting && full[ptr];
    assign out_data     = hold[ptr];
    assign out_ch       = ptr;
    assign out_sof      = out_valid && (ptr == '0);
    assign busy         = (state != ST_IDLE);
    assign filt_reset_n = (state != ST_IDLE);

    assign handshake = out_valid && out_ready;
    assign last_hs   = handshake && (ptr == LAST_CH);

    // Sequencer next-state: filter reset control, settle window and drain.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no
        // path through the case can leave it unassigned and infer a latch.
        state_nxt = state;
        go_idle   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (enable) begin
                    state_nxt = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                // Dropping enable aborts the settle window outright.
                if (!enable) begin
                    state_nxt = ST_IDLE;
                    go_idle   = 1'b1;
                end else if (settle_cnt == SETTLE_LAST) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!enable) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // The frame is finished either by accepting the last
                // channel or by finding the head slot empty: with captures
                // off, an empty head can never fill again.
                if (last_hs || !full[ptr]) begin
                    state_nxt = ST_IDLE;
                    go_idle   = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                go_idle   = 1'b1;
            end
        endcase
    end

    // Slot bookkeeping: release of the head slot is applied before a
    // capture, so a same-cycle release and capture on one channel refills
    // the slot rather than counting as an overrun.
    always_comb begin
        clear_vec = '0;
        if (handshake) begin
            clear_vec[ptr] = 1'b1;
        end

        capture = (state == ST_RUN) ? ch_valid : '0;
        drop    = capture & full & ~clear_vec;
        load    = capture & ~drop;

        full_nxt = (full & ~clear_vec) | load;

        ptr_nxt = ptr;
        if (handshake) begin
            ptr_nxt = (ptr == LAST_CH) ? '0 : ptr + CH_W'(1);
        end

        // Each return to IDLE discards whatever is still queued.
        if (go_idle) begin
            full_nxt = '0;
            ptr_nxt  = '0;
        end

        // A drop in the same cycle as a clear request keeps its bit set.
        overrun_nxt = (overrun_clr ? '0 : overrun) | drop;
    end

    // Sequencer, settle counter, slot flags, read pointer and overrun flags.
    always_ff @(posedge clk_in or negedge reset_n) begin
        // NOTE: state registers use non-blocking assignment so every
        // register samples pre-edge values regardless of statement order.
        if (!reset_n) begin
            state      <= ST_IDLE;
            settle_cnt <= '0;
            full       <= '0;
            ptr        <= '0;
            overrun    <= '0;
        end else begin
            state      <= state_nxt;
            // Counts only while settling; any other state parks it at zero
            // so each SETTLE entry starts a fresh window.
            settle_cnt <= (state == ST_SETTLE) ? settle_cnt + CNT_W'(1) : '0;
            full       <= full_nxt;
            ptr        <= ptr_nxt;
            overrun    <= overrun_nxt;
        end
    end

    // Sample holding slots, written only when their channel captures.
    always_ff @(posedge clk_in) begin
        // NOTE: the data slots are deliberately not reset; the full flags
        // gate their visibility, so a reset here would only cost routing.
        for (int k = 0; k < NUM_CH; k++) begin
            if (load[k]) begin
                hold[k] <= ch_data[k*DATA_W +: DATA_W];
            end
        end
    end

`ifdef MIC_SCHED_FRAME_CNT_EN
    logic [15:0] frame_cnt_q;

    // Completed-frame counter; survives IDLE, cleared only by reset.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            frame_cnt_q <= '0;
        end else if (last_hs) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign frame_cnt = frame_cnt_q;
`else
    assign frame_cnt = 16'd0;
`endif

endmodule
